alu_cmd_issuer: RTL and testbench

Sequential front-end that owns the operands for the team's 8-bit ALU opcode map and issues operations to it.
- Accepts commands over a valid/ready handshake and keeps a small register file.
- Reads operands from the register file, executes one ALU operation, writes the result back, and returns result plus flags over a valid/ready response channel.
- Sits between a controller or testbench command source and the combinational ALU datapath.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu8_flag_core.sv | 52 +++++
 rtl/alu_cmd_issuer.sv | 161 ++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU opcode map and the command issuer FSM.
package alu_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SHL = 3'b011;
    localparam logic [2:0] OP_SHR = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu8_flag_core.sv
// Combinational 8-bit ALU: result plus a single carry/borrow/overflow flag.
module alu8_flag_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] res,
    output logic              carry
);

    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        prod  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB: begin
                res   = a - b;
                carry = (a < b);
            end
            OP_MUL: begin
                res   = prod[DATA_W-1:0];
                carry = |prod[2*DATA_W-1:DATA_W];
            end
            // Shifts are single-operand; b is deliberately ignored.
            OP_SHL: begin
                res   = {a[DATA_W-2:0], 1'b0};
                carry = a[DATA_W-1];
            end
            OP_SHR: begin
                res   = {1'b0, a[DATA_W-1:1]};
                carry = a[0];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command front-end: register file, IDLE/EXEC/RESP sequencer, response registers
// and a saturating completed-command counter around alu8_flag_core.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int REG_AW = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ld,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_ra,
    input  logic [REG_AW-1:0] cmd_rb,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int NREGS = 1 << REG_AW;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NREGS];

    logic                ld_q;
    logic [2:0]          op_q;
    logic [REG_AW-1:0]   rd_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   opa_q;
    logic [DATA_W-1:0]   opb_q;

    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_carry_q;
    logic                rsp_zero_q;
    logic [CNT_W-1:0]    done_cnt_q;

    logic                accept;
    logic                exec_fire;
    logic                rsp_fire;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;
    logic [DATA_W-1:0]   exec_res;
    logic                exec_carry;

    alu8_flag_core u_core (
        .a     (opa_q),
        .b     (opb_q),
        .op    (op_q),
        .res   (alu_res),
        .carry (alu_carry)
    );

    // Loads bypass the ALU and never raise the flag.
    assign exec_res   = ld_q ? imm_q : alu_res;
    assign exec_carry = ld_q ? 1'b0  : alu_carry;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        exec_fire = 1'b0;
        rsp_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec_fire = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_fire = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are captured at acceptance, so rd == ra/rb sees pre-write values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_q  <= 1'b0;
            op_q  <= '0;
            rd_q  <= '0;
            imm_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else if (accept) begin
            ld_q  <= cmd_ld;
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            imm_q <= cmd_imm;
            opa_q <= regs_q[cmd_ra];
            opb_q <= regs_q[cmd_rb];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (exec_fire) begin
            regs_q[rd_q] <= exec_res;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else if (exec_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= exec_res;
            rsp_carry_q <= exec_carry;
            rsp_zero_q  <= (exec_res == '0);
        end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_q <= '0;
        end else if (rsp_fire && !(&done_cnt_q)) begin
            done_cnt_q <= done_cnt_q + 1'b1;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = !cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer: directed vector table, handshake corner sequences,
// randomized commands against an arithmetic reference model, and counter saturation.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_ld;
    logic [2:0] cmd_op;
    logic [1:0] cmd_rd, cmd_ra, cmd_rb;
    logic [7:0] cmd_imm;
    logic       rsp_valid, rsp_ready, rsp_carry, rsp_zero, busy;
    logic [7:0] rsp_data;
    logic [15:0] done_cnt;

    logic       s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready;
    logic       s_rsp_carry, s_rsp_zero, s_busy;
    logic [7:0] s_rsp_data;
    logic [1:0] s_done_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int s_hs  = 0;

    logic [7:0] mregs [4];
    int         mcnt;

    int         acc_q[$];
    logic [9:0] rsp_q[$];
    logic [9:0] exp_q[$];

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [1:0] rd, ra, rb;
        logic [7:0] imm;
        logic [7:0] e_data;
        logic       e_c, e_z;
    } vec_t;

    vec_t vt[15];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_carry, rsp_zero, rsp_data});
        if (s_rsp_valid && s_rsp_ready) s_hs++;
    end

    alu_cmd_issuer #(.REG_AW(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .busy(busy), .done_cnt(done_cnt)
    );

    alu_cmd_issuer #(.REG_AW(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_ld(1'b1), .cmd_op(3'b000),
        .cmd_rd(2'd0), .cmd_ra(2'd0), .cmd_rb(2'd0), .cmd_imm(8'h5A),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
        .rsp_carry(s_rsp_carry), .rsp_zero(s_rsp_zero), .busy(s_busy), .done_cnt(s_done_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic over an array of registers.
    function automatic void model_exec(input logic ld, input logic [2:0] op,
                                       input logic [1:0] rd, input logic [1:0] ra,
                                       input logic [1:0] rb, input logic [7:0] imm,
                                       output logic [7:0] r, output logic c);
        int a, b, v;
        a = int'(mregs[ra]);
        b = int'(mregs[rb]);
        c = 1'b0;
        if (ld) v = int'(imm);
        else begin
            case (op)
                3'd0: begin v = a + b; c = (v > 255); end
                3'd1: begin v = a - b; c = (a < b); if (v < 0) v += 256; end
                3'd2: begin v = a * b; c = (v > 255); end
                3'd3: begin v = a * 2; c = (a >= 128); end
                3'd4: begin v = a / 2; c = (a % 2 == 1); end
                3'd5: v = a & b;
                3'd6: v = a | b;
                default: v = a ^ b;
            endcase
        end
        r = 8'(v % 256);
        mregs[rd] = r;
        if (mcnt < 65535) mcnt++;
    endfunction

    task automatic drive_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm);
        cmd_ld = ld; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        cmd_valid = 1'b1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!cmd_ready && n < 20);
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 10);
        chk("rsp_valid_wait", rsp_valid, 1);
    endtask

    task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm,
                          output logic [7:0] gd, output logic gc, output logic gz);
        logic [7:0] er;
        logic       ec;
        int         n;
        model_exec(ld, op, rd, ra, rb, imm, er, ec);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drive_cmd(ld, op, rd, ra, rb, imm);
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(n);
        chk("latency", n, 2);
        gd = rsp_data; gc = rsp_carry; gz = rsp_zero;
        chk("model_data", rsp_data, er);
        chk("model_carry", rsp_carry, ec);
        chk("model_zero", rsp_zero, (er == 8'h00));
        @(negedge clk);
        chk("rsp_drop", rsp_valid, 0);
        chk("done_cnt", done_cnt, mcnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] gd, er, d0;
        logic       gc, gz, ec;
        int         n;

        vt[0]  = '{1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 8'hC8, 8'hC8, 1'b0, 1'b0};
        vt[1]  = '{1'b1, OP_ADD, 2'd2, 2'd0, 2'd0, 8'h64, 8'h64, 1'b0, 1'b0};
        vt[2]  = '{1'b0, OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 8'h2C, 1'b1, 1'b0};
        vt[3]  = '{1'b0, OP_SUB, 2'd0, 2'd2, 2'd1, 8'h00, 8'h9C, 1'b1, 1'b0};
        vt[4]  = '{1'b0, OP_SUB, 2'd0, 2'd1, 2'd1, 8'h00, 8'h00, 1'b0, 1'b1};
        vt[5]  = '{1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 8'h10, 8'h10, 1'b0, 1'b0};
        vt[6]  = '{1'b1, OP_ADD, 2'd2, 2'd0, 2'd0, 8'h11, 8'h11, 1'b0, 1'b0};
        vt[7]  = '{1'b0, OP_MUL, 2'd3, 2'd1, 2'd2, 8'h00, 8'h10, 1'b1, 1'b0};
        vt[8]  = '{1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h81, 8'h81, 1'b0, 1'b0};
        vt[9]  = '{1'b0, OP_SHL, 2'd1, 2'd0, 2'd3, 8'h00, 8'h02, 1'b1, 1'b0};
        vt[10] = '{1'b0, OP_SHR, 2'd2, 2'd0, 2'd3, 8'h00, 8'h40, 1'b1, 1'b0};
        vt[11] = '{1'b0, OP_AND, 2'd3, 2'd0, 2'd2, 8'h00, 8'h00, 1'b0, 1'b1};
        vt[12] = '{1'b0, OP_OR,  2'd3, 2'd0, 2'd1, 8'h00, 8'h83, 1'b0, 1'b0};
        vt[13] = '{1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h01, 8'h01, 1'b0, 1'b0};
        vt[14] = '{1'b0, OP_XOR, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1};

        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        mcnt = 0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = 3'd0;
        cmd_rd = 2'd0; cmd_ra = 2'd0; cmd_rb = 2'd0; cmd_imm = 8'h00;
        rsp_ready = 1'b0;
        s_cmd_valid = 1'b0; s_rsp_ready = 1'b1;

        #12;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_flags", {rsp_carry, rsp_zero}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Narrow counter instance must stop at all-ones rather than wrap.
        @(posedge clk); #1;
        s_cmd_valid = 1'b1;
        n = 0;
        while (s_hs < 5 && n < 100) begin @(posedge clk); n++; end
        #1;
        s_cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("sat_handshakes", (s_hs >= 5), 1);
        chk("sat_done_cnt", s_done_cnt, 2'b11);

        for (int i = 0; i < 15; i++) begin
            do_cmd(vt[i].ld, vt[i].op, vt[i].rd, vt[i].ra, vt[i].rb, vt[i].imm, gd, gc, gz);
            chk($sformatf("vec%0d_data", i), gd, vt[i].e_data);
            chk($sformatf("vec%0d_carry", i), gc, vt[i].e_c);
            chk($sformatf("vec%0d_zero", i), gz, vt[i].e_z);
            if (i == 2) chk("done_cnt_after_add", done_cnt, 3);
        end

        // Back-pressured response with a second command held pending.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        drive_cmd(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 8'h55);
        model_exec(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 8'h55, er, ec);
        wait_ready();
        @(posedge clk); #1;
        drive_cmd(1'b0, OP_ADD, 2'd2, 2'd1, 2'd1, 8'h00);
        wait_rsp(n);
        d0 = rsp_data;
        chk("hold_first", d0, 8'h55);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_data", rsp_data, d0);
            chk("hold_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("release_idle", cmd_ready, 1);
        chk("release_rsp_drop", rsp_valid, 0);
        chk("release_cnt", done_cnt, mcnt);
        model_exec(1'b0, OP_ADD, 2'd2, 2'd1, 2'd1, 8'h00, er, ec);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("pending_accepted", busy, 1);
        wait_rsp(n);
        chk("pending_data", rsp_data, 8'hAA);
        chk("pending_model", rsp_data, er);
        @(negedge clk);

        // Dependent chain with cmd_valid held high: one acceptance every 3 cycles.
        acc_q.delete(); rsp_q.delete(); exp_q.delete();
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin drive_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h01);
                         model_exec(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h01, er, ec); end
                1: begin drive_cmd(1'b0, OP_XOR, 2'd0, 2'd0, 2'd0, 8'h00);
                         model_exec(1'b0, OP_XOR, 2'd0, 2'd0, 2'd0, 8'h00, er, ec); end
                2: begin drive_cmd(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 8'h07);
                         model_exec(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 8'h07, er, ec); end
                default: begin drive_cmd(1'b0, OP_ADD, 2'd2, 2'd1, 2'd1, 8'h00);
                         model_exec(1'b0, OP_ADD, 2'd2, 2'd1, 2'd1, 8'h00, er, ec); end
            endcase
            exp_q.push_back({ec, (er == 8'h00), er});
            wait_ready();
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("chain_accepts", acc_q.size(), 4);
        for (int k = 1; k < acc_q.size(); k++) chk("chain_spacing", acc_q[k] - acc_q[k-1], 3);
        chk("chain_rsps", rsp_q.size(), 4);
        for (int k = 0; k < rsp_q.size() && k < exp_q.size(); k++) chk("chain_rsp", rsp_q[k], exp_q[k]);
        if (rsp_q.size() > 1) chk("chain_xor_zero", rsp_q[1], 10'h100);
        chk("chain_cnt", done_cnt, mcnt);

        for (int i = 0; i < 40; i++) begin
            do_cmd(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), gd, gc, gz);
        end

        // Asynchronous reset during EXEC aborts the write and the response.
        do_cmd(1'b1, OP_ADD, 2'd0, 2'd0, 2'd0, 8'h05, gd, gc, gz);
        do_cmd(1'b1, OP_ADD, 2'd1, 2'd0, 2'd0, 8'h09, gd, gc, gz);
        @(posedge clk); #1;
        drive_cmd(1'b0, OP_ADD, 2'd3, 2'd0, 2'd1, 8'h00);
        wait_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #2;
        chk("exec_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", done_cnt, 0);
        chk("arst_data", rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        mcnt = 0;
        do_cmd(1'b0, OP_OR, 2'd2, 2'd3, 2'd3, 8'h00, gd, gc, gz);
        chk("r3_after_abort", gd, 8'h00);
        do_cmd(1'b0, OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, gd, gc, gz);
        chk("regs_cleared", gd, 8'h00);
        chk("cnt_after_reset", done_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
